instruction_fetch_unit: RTL and testbench

Upstream neighbour of the combinational instruction ROM in the ARM calculator datapath. Owns the program counter and drives the ROM address. Registers the returned 32-bit instruction into an IF/ID pipeline register for the decoder. Supports stall, branch redirect/flush, and a sticky halt at the end of the program image.

---
 rtl/instruction_fetch_unit.sv | 115 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction ROM address and registers the IF/ID stage.
// Optional performance counters are built when FETCH_PERF_EN is defined.

// state   | meaning
// RUN     | fetching, honouring branch / end-of-image / stall in that priority
// HALTED  | PC reached END_ADDR; everything frozen until reset
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] END_ADDR     = 32'd64
`ifdef FETCH_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus8,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  , output logic [CNT_W-1:0] fetch_count
  , output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_nxt, ipc_nxt, ip8_nxt;
  logic        valid_nxt;
  logic        do_fetch, do_flush;

  assign imem_addr = pc;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      if_id_instr    <= 32'h0;
      if_id_pc       <= 32'h0;
      if_id_pc_plus8 <= 32'd8;
      if_id_valid    <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      if_id_instr    <= instr_nxt;
      if_id_pc       <= ipc_nxt;
      if_id_pc_plus8 <= ip8_nxt;
      if_id_valid    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = if_id_instr;
    ipc_nxt   = if_id_pc;
    ip8_nxt   = if_id_pc_plus8;
    valid_nxt = if_id_valid;
    do_fetch  = 1'b0;
    do_flush  = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          // Masking instead of slicing keeps every target bit in use; low bits are forced to zero.
          pc_nxt    = branch_target & 32'hFFFF_FFFC;
          instr_nxt = 32'h0;
          valid_nxt = 1'b0;
          do_flush  = 1'b1;
        end else if (pc == END_ADDR) begin
          state_nxt = HALTED;
          instr_nxt = 32'h0;
          valid_nxt = 1'b0;
        end else if (!stall) begin
          instr_nxt = imem_data;
          ipc_nxt   = pc;
          ip8_nxt   = pc + 32'd8;
          valid_nxt = 1'b1;
          pc_nxt    = pc + 32'd4;
          do_fetch  = 1'b1;
        end
      end
      HALTED: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (do_fetch && (fetch_count != {CNT_W{1'b1}})) fetch_count <= fetch_count + CNT_ONE;
      if (do_flush && (flush_count != {CNT_W{1'b1}})) flush_count <= flush_count + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed plan steps plus a randomized phase against a rule-level model.
// Perf-counter checks are included when FETCH_PERF_EN is defined.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus8;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] rom [16];
  assign imem_data = rom[imem_addr[5:2]];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ipc, m_ip8;
  logic        m_valid, m_halt;
  int          m_fc, m_flc;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus8 (if_id_pc_plus8),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    , .fetch_count  (fetch_count)
    , .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ip8 = 32'd8;
    m_valid = 1'b0; m_halt = 1'b0; m_fc = 0; m_flc = 0;
  endtask

  // Applies the fetch rules for one rising edge using the currently driven inputs.
  task automatic model_edge();
    if (m_halt) return;
    if (branch_taken) begin
      m_pc = {branch_target[31:2], 2'b00};
      m_instr = 32'h0; m_valid = 1'b0; m_flc++;
    end else if (m_pc == 32'd64) begin
      m_halt = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = rom[m_pc[5:2]]; m_ipc = m_pc; m_ip8 = m_pc + 32'd8;
      m_valid = 1'b1; m_pc = m_pc + 32'd4; m_fc++;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".if_id_pc"}, if_id_pc, m_ipc);
    chk({tag, ".pc_plus8"}, if_id_pc_plus8, m_ip8);
    chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, m_halt});
`ifdef FETCH_PERF_EN
    chk({tag, ".fetch_count"}, {16'h0, fetch_count}, m_fc[31:0] & 32'hFFFF);
    chk({tag, ".flush_count"}, {16'h0, flush_count}, m_flc[31:0] & 32'hFFFF);
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
  endtask

  // Asserts reset between edges and checks the asynchronous effect before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    rom[0] = 32'hE381_1F63;
    for (int i = 1; i < 16; i++) rom[i] = $urandom;
    rom[3] = 32'h0;
    model_reset();

    // 1: reset values, then first fetch
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    reset_n = 1'b1;
    chk("t1.addr_pre", imem_addr, 32'h0);
    cycle("t1");
    chk("t1.instr", if_id_instr, 32'hE381_1F63);
    chk("t1.pc", if_id_pc, 32'h0);
    chk("t1.p8", if_id_pc_plus8, 32'd8);
    chk("t1.next", imem_addr, 32'd4);

    // 2: stall at pc 8 for three cycles
    cycle("t2.pre");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("t2.stall");
      chk("t2.addr_hold", imem_addr, 32'd8);
      chk("t2.ipc_hold", if_id_pc, 32'd4);
    end
    stall = 1'b0;
    cycle("t2.post");
    chk("t2.ipc", if_id_pc, 32'd8);
    chk("t2.addr", imem_addr, 32'd12);

    // 3: misaligned branch at pc 20
    cycle("t3.a");
    cycle("t3.b");
    chk("t3.at20", imem_addr, 32'd20);
    branch_taken = 1'b1; branch_target = 32'h2E;
    cycle("t3.br");
    chk("t3.addr", imem_addr, 32'h2C);
    chk("t3.valid0", {31'h0, if_id_valid}, 32'h0);
    chk("t3.instr0", if_id_instr, 32'h0);
    branch_taken = 1'b0;
    cycle("t3.after");
    chk("t3.ipc", if_id_pc, 32'h2C);
    chk("t3.valid1", {31'h0, if_id_valid}, 32'h1);

    // 4: branch beats stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h30;
    cycle("t4");
    chk("t4.addr", imem_addr, 32'h30);
    chk("t4.valid", {31'h0, if_id_valid}, 32'h0);
    stall = 1'b0; branch_taken = 1'b0;

    // Randomized phase with occasional resets and wrap-around targets
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0: branch_target = 32'hFFFF_FFF8 | {30'h0, 2'($urandom)};
        default: branch_target = $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 59) == 0) begin
        stall = 1'b0; branch_taken = 1'b0;
        do_reset("rnd.reset");
      end else begin
        cycle("rnd");
      end
    end
    stall = 1'b0; branch_taken = 1'b0;

    // 5: free-run to halt, then branch is ignored
    do_reset("t5.reset");
    for (int i = 0; i < 16; i++) begin
      cycle("t5.run");
      chk("t5.ipc", if_id_pc, i * 4);
      chk("t5.valid", {31'h0, if_id_valid}, 32'h1);
    end
    cycle("t5.halt");
    chk("t5.halted", {31'h0, halted}, 32'h1);
    chk("t5.valid0", {31'h0, if_id_valid}, 32'h0);
    branch_taken = 1'b1; branch_target = 32'h0;
    cycle("t5.br");
    chk("t5.pc_stuck", imem_addr, 32'd64);
    branch_taken = 1'b0;
    cycle("t5.hold");

    // 6: async reset mid-cycle at pc 36
    do_reset("t6.pre");
    for (int i = 0; i < 9; i++) cycle("t6.run");
    chk("t6.at36", imem_addr, 32'd36);
    do_reset("t6.async");
    chk("t6.addr", imem_addr, 32'h0);
    chk("t6.p8", if_id_pc_plus8, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
